bram_unloader: RTL and testbench
================================

# bram_unloader

Read-out stage directly downstream of the 16-bank BRAM chain (8 A-banks, 8 B-banks) in the 8-butterfly NTT datapath. After a transform completes, it sweeps a contiguous region of word addresses across all 16 banks in parallel. Each word's 16 coefficients are packed into one beat, and beats leave on a valid/ready stream toward the host/output interface. Backpressure is absorbed by a 2-entry buffer that accounts for the BRAMs' fixed 1-cycle read latency, since the banks have no read enable.

## Interface
- DATA_WIDTH, 12, coefficient width
- NUM_LANES, 16, banks read per word (lanes 0–7 = A-banks 0–7, lanes 8–15 = B-banks 0–7)
- OUT_WIDTH, DATA_WIDTH*NUM_LANES (192), beat width
- ADDR_WIDTH, 5, bank word-address width
- NUM_WORDS, 16, words read per sweep (256 coefficients / 16 banks)

- clk_i  in  1  single clock, rising edge
- rst_i  in  1  asynchronous, active-low reset
- start_i  in  1  begin sweep; sampled only in IDLE
- base_addr_i  in  ADDR_WIDTH  first word address; latched with start_i
- busy_o  out  1  high from the cycle after start is accepted until done_o
- done_o  out  1  one-cycle pulse at sweep end
- rd_addr_o  out  ADDR_WIDTH  word address, fanned out to all 16 bank address ports
- data_bram_i  in  NUM_LANES*DATA_WIDTH  bank read data; lane k at [k*DATA_WIDTH +: DATA_WIDTH]
- m_data_o  out  OUT_WIDTH  packed beat, same lane order
- m_valid_o  out  1  beat valid
- m_ready_i  in  1  consumer ready
- m_last_o  out  1  high with the final beat (word NUM_WORDS-1)

## Operation
- FSM has three states: IDLE, READ, DRAIN.
- IDLE to READ on start_i:
  - latch base_addr_i;
  - clear issue_cnt and beat_cnt.
- start_i is ignored outside IDLE.
- READ, issue rule:
  - issue when issue_cnt < NUM_WORDS and (fifo_cnt + inflight − pop) < 2, where pop = m_valid_o & m_ready_i;
  - on issue, rd_addr_o = base + issue_cnt, modulo 2^ADDR_WIDTH (wraps: base 30 gives 30, 31, 0 … 13);
  - the issue sets inflight for the next cycle.
- Capture: when inflight is high, data_bram_i is written into the FIFO at the end of that cycle.
- READ to DRAIN when the last word is issued.
- DRAIN to IDLE after the handshake of the beat with m_last_o; done_o pulses in the following cycle.
- When not issuing, rd_addr_o holds its last value. A re-read is harmless; only issued reads are captured.
- Stream rules:
  - m_data_o and m_last_o are stable while m_valid_o & !m_ready_i;
  - m_valid_o never drops without a handshake;
  - beats are emitted in address order;
  - no beat is lost or duplicated.
- Reset mid-sweep: state returns to IDLE, FIFO is flushed, in-flight data is discarded, and no done_o is generated.
- The reset value of every output is 0.

## Timing
- Start sampled at edge E0 → READ in cycle 1 → first address issued in cycle 1.
- Bank data is valid in cycle 2 and captured at the end of cycle 2; first m_valid_o in cycle 3.
- With m_ready_i held high, throughput is 1 beat/cycle: beats in cycles 3–18, m_last_o in cycle 18, done_o in cycle 19, busy_o low from cycle 19.
- Latency from issue to beat is 2 cycles. At most 2 words are outstanding (FIFO + in flight), so a stall never overruns the buffer.
- m_ready_i low indefinitely: issue stops with 2 words held; the sweep resumes without bubbles on release.
- A new start_i is accepted in the same cycle done_o is high (state is already IDLE).

## Structure
- Shared package ntt_pkg holds:
  - DATA_WIDTH, ADDR_WIDTH, NUM_LANES, NUM_WORDS;
  - the FSM enum (IDLE, READ, DRAIN);
  - the lane-index constants for the A/B bank ordering.
- Sub-module bram_unload_fifo: a 2-entry, OUT_WIDTH+1 bits wide FIFO (data + last) with count output, push/pop, and full/empty flags.
- The top level holds the FSM, the issue and beat counters, and the credit logic.

## Test plan
- Directed read-out: banks preloaded with coefficient = lane*32+addr, base 0, m_ready_i constantly 1 → 16 beats in cycles 3–18, beat w has lane k = k*32+w, m_last_o only on beat 15, done_o in cycle 19.
- Backpressure: m_ready_i toggling 1 cycle high / 2 low with random hold → beats identical and in order, data stable under stall, rd_addr_o never more than 2 ahead of accepted beats.
- Wrap-around: base 30 → addresses 30, 31, 0 … 13; beat 2 contains word 0.
- Ready low for 50 cycles right after start → exactly 2 issues, then no further issue until release; all 16 beats later correct.
- Reset asserted mid-sweep (after beat 5) → all outputs 0 asynchronously, no done_o. A following start with base 4 gives a clean sweep of 4–19.
- start_i pulsed while busy, and again in the done_o cycle → the first pulse is ignored, the second starts a new sweep with cycle-3 first beat.

Source files
------------

// File: rtl/ntt_pkg.sv
// Shared constants and types for the NTT BRAM read-out path.
// Lanes 0..7 carry A-banks 0..7, lanes 8..15 carry B-banks 0..7.
package ntt_pkg;

    localparam int DATA_WIDTH = 12;
    localparam int NUM_LANES  = 16;
    localparam int ADDR_WIDTH = 5;
    localparam int NUM_WORDS  = 16;
    localparam int OUT_WIDTH  = DATA_WIDTH * NUM_LANES;
    localparam int CNT_WIDTH  = $clog2(NUM_WORDS + 1);

    localparam int BANKS_PER_SET = 8;
    localparam int A_LANE_BASE   = 0;
    localparam int B_LANE_BASE   = BANKS_PER_SET;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } unload_state_e;

endpackage

// File: rtl/bram_unload_fifo.sv
// Two-entry FIFO holding captured beats (data plus last flag) in front of the output stream.
module bram_unload_fifo #(
    parameter int WIDTH = 193
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic [1:0]       count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count == 2'd0);
    assign full_o  = (count == 2'd2);
    assign count_o = count;
    assign head_o  = mem[rd_ptr];
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || pop_i);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < 2; i++) mem[i] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data_i;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/bram_unloader.sv
// Sweeps NUM_WORDS word addresses across all banks and streams each word as one packed beat.
// A two-word credit (FIFO entries plus the read in flight) keeps the no-enable banks from overrunning the buffer.
module bram_unloader
    import ntt_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [ADDR_WIDTH-1:0] rd_addr_o,
    input  logic [OUT_WIDTH-1:0]  data_bram_i,
    output logic [OUT_WIDTH-1:0]  m_data_o,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic                  m_last_o
);

    localparam logic [CNT_WIDTH-1:0] WORDS_C = CNT_WIDTH'(NUM_WORDS);
    localparam logic [CNT_WIDTH-1:0] LAST_C  = CNT_WIDTH'(NUM_WORDS - 1);

    unload_state_e         state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [ADDR_WIDTH-1:0] last_addr_q;
    logic [CNT_WIDTH-1:0]  issue_cnt;
    logic [CNT_WIDTH-1:0]  beat_cnt;
    logic                  inflight;
    logic                  issue;
    logic                  pop;
    logic                  credit_ok;
    logic                  done_q;
    logic [1:0]            fifo_cnt;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [OUT_WIDTH:0]    fifo_head;

    assign pop       = m_valid_o & m_ready_i;
    // Words already owed (buffered + in flight) minus the one leaving now must stay below 2.
    assign credit_ok = ({1'b0, fifo_cnt} + {2'b00, inflight}) < (3'd2 + {2'b00, pop});

    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) state_d = READ;
            end
            READ: begin
                if (issue_cnt < WORDS_C && credit_ok) begin
                    issue = 1'b1;
                    if (issue_cnt == LAST_C) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && m_last_o) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Address holds between issues; the banks keep re-reading it but nothing is captured.
    assign rd_addr_o = issue ? base_q + ADDR_WIDTH'(issue_cnt) : last_addr_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            base_q      <= '0;
            last_addr_q <= '0;
            issue_cnt   <= '0;
            beat_cnt    <= '0;
            inflight    <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_addr_q <= rd_addr_o;
            inflight    <= issue;
            done_q      <= (state_q == DRAIN) && pop && m_last_o;
            if (state_q == IDLE && start_i) begin
                base_q    <= base_addr_i;
                issue_cnt <= '0;
                beat_cnt  <= '0;
            end else begin
                if (issue)    issue_cnt <= issue_cnt + 1'b1;
                if (inflight) beat_cnt  <= beat_cnt + 1'b1;
            end
        end
    end

    bram_unload_fifo #(
        .WIDTH(OUT_WIDTH + 1)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (inflight),
        .push_data_i ({beat_cnt == LAST_C, data_bram_i}),
        .pop_i       (pop),
        .head_o      (fifo_head),
        .count_o     (fifo_cnt),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign m_valid_o = !fifo_empty;
    assign m_data_o  = fifo_head[OUT_WIDTH-1:0];
    assign m_last_o  = fifo_head[OUT_WIDTH] & m_valid_o;
    assign busy_o    = (state_q != IDLE);
    assign done_o    = done_q;

    // A capture into a full buffer with no beat leaving would drop a word.
    assert property (@(posedge clk_i) disable iff (!rst_i) !(inflight && fifo_full && !pop));

endmodule

// File: tb/tb_bram_unloader.sv
// Scoreboard bench for bram_unloader: a bank model feeds the DUT, a word-level model predicts beats.
module tb_bram_unloader;
    import ntt_pkg::*;

    localparam int DW = DATA_WIDTH;
    localparam int NL = NUM_LANES;
    localparam int AW = ADDR_WIDTH;
    localparam int NW = NUM_WORDS;
    localparam int OW = OUT_WIDTH;

    typedef struct packed {
        logic          l;
        logic [OW-1:0] d;
    } beat_t;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b0;
    logic          start_i = 1'b0;
    logic [AW-1:0] base_addr_i = '0;
    logic          busy_o, done_o, m_valid_o, m_last_o;
    logic [AW-1:0] rd_addr_o;
    logic [OW-1:0] data_bram_i = '0;
    logic [OW-1:0] m_data_o;
    logic          m_ready_i = 1'b0;

    always #5 clk_i = ~clk_i;

    bram_unloader dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .base_addr_i (base_addr_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .rd_addr_o   (rd_addr_o),
        .data_bram_i (data_bram_i),
        .m_data_o    (m_data_o),
        .m_valid_o   (m_valid_o),
        .m_ready_i   (m_ready_i),
        .m_last_o    (m_last_o)
    );

    // Bank array with a fixed one-cycle registered read and no enable.
    logic [DW-1:0] bram [NL][1 << AW];
    always @(posedge clk_i)
        for (int k = 0; k < NL; k++) data_bram_i[k*DW +: DW] <= bram[k][rd_addr_o];

    int     checks = 0;
    int     passes = 0;
    beat_t  exp_q[$];
    int     accepted = 0;
    int     done_cnt = 0;
    int     exp_done = 0;
    logic [AW-1:0] cur_base = '0;
    time    start_t = 0;
    bit     timing_chk = 1'b0;
    int     rdy_mode = 0;

    task automatic check(input string nm, input logic [OW+1:0] act, input logic [OW+1:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic logic [OW-1:0] word_at(input int a);
        logic [OW-1:0] w;
        for (int k = 0; k < NL; k++) w[k*DW +: DW] = bram[k][a % (1 << AW)];
        return w;
    endfunction

    task automatic fill(input int salt);
        for (int k = 0; k < NL; k++)
            for (int a = 0; a < (1 << AW); a++) bram[k][a] = DW'((k * 32 + a) ^ salt);
    endtask

    // Ready patterns: 0 always high, 1 one-high/two-low with random holds, 2 random, 3 held low.
    int ph = 0;
    always @(posedge clk_i) begin
        #1;
        case (rdy_mode)
            0: m_ready_i = 1'b1;
            1: begin
                if ($urandom_range(3) != 0) ph = (ph + 1) % 3;
                m_ready_i = (ph == 0);
            end
            2: m_ready_i = 1'($urandom_range(1));
            default: m_ready_i = 1'b0;
        endcase
    end

    // Monitor: samples mid-cycle, between input updates and the next active edge.
    bit            prev_stall = 1'b0;
    logic [OW:0]   prev_beat = '0;
    int            c;
    logic [AW-1:0] diff;
    beat_t         e;
    always @(negedge clk_i) begin
        if (!rst_i) begin
            prev_stall = 1'b0;
        end else begin
            c = int'(($time - start_t + 5) / 10);
            if (prev_stall)
                check("stall_hold", {m_valid_o, m_last_o, m_data_o}, {1'b1, prev_beat});
            if (busy_o) begin
                diff = rd_addr_o - cur_base;
                check("issue_ahead", int'(diff) < accepted + int'(m_valid_o && m_ready_i) + 2, 1);
            end
            if (m_valid_o && m_ready_i) begin
                check("beat_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("beat_data", {m_last_o, m_data_o}, {e.l, e.d});
                end
                if (timing_chk && accepted == 0) check("first_beat_cycle", c, 3);
                if (timing_chk && m_last_o) check("last_beat_cycle", c, 18);
                accepted++;
            end
            if (done_o) begin
                done_cnt++;
                check("done_queue_empty", exp_q.size(), 0);
                check("busy_low_at_done", busy_o, 0);
                if (timing_chk) check("done_cycle", c, 19);
            end
            prev_stall = m_valid_o && !m_ready_i;
            prev_beat  = {m_last_o, m_data_o};
        end
    end

    // Enter and leave at one time unit after a rising edge.
    task automatic start_sweep(input logic [AW-1:0] b, input bit accept);
        start_i     = 1'b1;
        base_addr_i = b;
        @(posedge clk_i);
        if (accept) begin
            start_t  = $time;
            cur_base = b;
            accepted = 0;
            exp_done++;
            for (int w = 0; w < NW; w++) exp_q.push_back({w == NW - 1, word_at(int'(b) + w)});
        end
        #1;
        start_i     = 1'b0;
        base_addr_i = AW'($urandom);
    endtask

    task automatic wait_done();
        bit got = 1'b0;
        for (int i = 0; i < 2000 && !got; i++) begin
            @(posedge clk_i);
            #1;
            if (done_o) got = 1'b1;
        end
        check("done_seen", got, 1);
    endtask

    initial begin
        int dc;
        fill(0);
        repeat (3) @(posedge clk_i);
        #1;
        check("reset_ctrl", {busy_o, done_o, m_valid_o, m_last_o, rd_addr_o}, 0);
        check("reset_data", m_data_o, 0);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;

        // Directed read-out, ready always high.
        timing_chk = 1'b1;
        start_sweep(0, 1);
        wait_done();
        timing_chk = 1'b0;

        // Start while busy is ignored; start in the done cycle is taken.
        start_sweep(7, 1);
        repeat (4) begin @(posedge clk_i); #1; end
        start_sweep(20, 0);
        wait_done();
        timing_chk = 1'b1;
        start_sweep(9, 1);
        wait_done();
        timing_chk = 1'b0;

        // Wrap-around under 1-high/2-low backpressure.
        rdy_mode = 1;
        start_sweep(30, 1);
        wait_done();

        // Ready held low for 50 cycles right after start.
        rdy_mode = 3;
        start_sweep(12, 1);
        repeat (50) begin @(posedge clk_i); #1; end
        check("stall_addr", rd_addr_o, 13);
        check("stall_valid", m_valid_o, 1);
        rdy_mode = 0;
        wait_done();

        // Randomized contents, bases and backpressure.
        for (int s = 0; s < 6; s++) begin
            fill(int'($urandom_range(4095)));
            rdy_mode = int'($urandom_range(1, 2));
            start_sweep(AW'($urandom), 1);
            wait_done();
        end

        // Reset mid-sweep after beat 5.
        fill(0);
        rdy_mode = 2;
        start_sweep(3, 1);
        for (int i = 0; i < 500 && accepted < 6; i++) begin @(posedge clk_i); #1; end
        check("reached_beat6", accepted >= 6, 1);
        #2;
        rst_i = 1'b0;
        #1;
        check("midrst_ctrl", {busy_o, done_o, m_valid_o, m_last_o, rd_addr_o}, 0);
        check("midrst_data", m_data_o, 0);
        exp_q.delete();
        exp_done--;
        dc = done_cnt;
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        repeat (30) begin @(posedge clk_i); #1; end
        check("no_done_after_rst", done_cnt, dc);
        rdy_mode = 0;
        timing_chk = 1'b1;
        start_sweep(4, 1);
        wait_done();
        timing_chk = 1'b0;

        repeat (3) begin @(posedge clk_i); #1; end
        check("done_count", done_cnt, exp_done);
        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
